// File: rtl/muestreo_scheduler.sv
// Sampling scheduler for the servo loop: programmable tick/sample clock generator
// plus a per-tick ADC -> controller -> PWM-load sequencer with overrun/timeout flags.
module muestreo_scheduler #(
  parameter int unsigned CNT_W      = 19,
  parameter int unsigned DEF_PERIOD = 500000,
  parameter int unsigned TMO        = 4095
) (
  input  logic             Clck_in,
  input  logic             reset_Clock,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_in,
  input  logic             period_load,
  input  logic             adc_done,
  input  logic             ctrl_done,
  output logic             sample_clk,
  output logic             sample_tick,
  output logic             adc_start,
  output logic             ctrl_start,
  output logic             pwm_load,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  output logic [15:0]      sample_count
);

  localparam int unsigned WAIT_W = $clog2(TMO + 1);
  localparam int unsigned SCNT_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADC       = 3'd1,
    WAIT_ADC  = 3'd2,
    CTRL      = 3'd3,
    WAIT_CTRL = 3'd4,
    LOAD      = 3'd5
  } state_t;

  logic [CNT_W-1:0]  period_reg;
  logic [CNT_W-1:0]  cnt;
  logic              wrap;

  state_t            state;
  state_t            state_nx;
  logic [WAIT_W-1:0] wcnt;
  logic [WAIT_W-1:0] wcnt_nx;
  logic              wait_expired;
  logic              tmo_hit;
  logic              ovr_hit;

  // ">=" rather than "==" so a period shrunk below the running count wraps at once
  assign wrap         = (cnt >= (period_reg - CNT_W'(1)));
  assign wait_expired = (wcnt == WAIT_W'(TMO - 1));

  // Period register and tick generator
  always_ff @(posedge Clck_in or posedge reset_Clock) begin
    if (reset_Clock) begin
      period_reg  <= CNT_W'(DEF_PERIOD);
      cnt         <= '0;
      sample_tick <= 1'b0;
      sample_clk  <= 1'b0;
    end else begin
      if (period_load && (period_in >= CNT_W'(2))) begin
        period_reg <= period_in;
      end
      if (!enable) begin
        cnt         <= '0;
        sample_tick <= 1'b0;
        sample_clk  <= 1'b0;
      end else if (wrap) begin
        cnt         <= '0;
        sample_tick <= 1'b1;
        sample_clk  <= ~sample_clk;
      end else begin
        cnt         <= cnt + CNT_W'(1);
        sample_tick <= 1'b0;
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge Clck_in or posedge reset_Clock) begin
    if (reset_Clock) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Sequencer next state; done inputs are only looked at in the WAIT states
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    tmo_hit  = 1'b0;
    ovr_hit  = 1'b0;

    unique case (state)
      IDLE: begin
        if (sample_tick) state_nx = ADC;
      end
      ADC: begin
        wcnt_nx  = '0;
        state_nx = WAIT_ADC;
      end
      WAIT_ADC: begin
        if (adc_done) begin
          state_nx = CTRL;
        end else if (wait_expired) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end else begin
          wcnt_nx = wcnt + WAIT_W'(1);
        end
      end
      CTRL: begin
        wcnt_nx  = '0;
        state_nx = WAIT_CTRL;
      end
      WAIT_CTRL: begin
        if (ctrl_done) begin
          state_nx = LOAD;
        end else if (wait_expired) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end else begin
          wcnt_nx = wcnt + WAIT_W'(1);
        end
      end
      LOAD: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // A tick that lands outside IDLE is dropped; the running sequence carries on
    if (sample_tick && (state != IDLE)) ovr_hit = 1'b1;

    if (!enable) begin
      state_nx = IDLE;
      wcnt_nx  = '0;
      tmo_hit  = 1'b0;
      ovr_hit  = 1'b0;
    end
  end

  // Registered handshake pulses, status and sticky flags
  always_ff @(posedge Clck_in or posedge reset_Clock) begin
    if (reset_Clock) begin
      adc_start    <= 1'b0;
      ctrl_start   <= 1'b0;
      pwm_load     <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      sample_count <= '0;
    end else begin
      adc_start  <= (state_nx == ADC);
      ctrl_start <= (state_nx == CTRL);
      pwm_load   <= (state_nx == LOAD);
      busy       <= (state_nx != IDLE);
      if (state_nx == LOAD) sample_count <= sample_count + SCNT_W'(1);
      if (tmo_hit)          timeout_err  <= 1'b1;
      if (ovr_hit)          overrun      <= 1'b1;
    end
  end

endmodule
